aes_byte_port: RTL and testbench
================================

# aes_byte_port

Chip-side byte-stream port of the AES-128 chip: the responder end of the 9-bit platform link (8 data bits plus a strobe in each direction). It deserializes strobed bytes from the verification platform into a 128-bit key and a 128-bit text block and starts the AES core. When the core finishes, it serializes the 128-bit result back to the platform, one strobed byte at a time. It sits between the chip pads and the AES core datapath, in the chip clock domain.

## Interface
- `SHO_HIGH`, default 25: chip clocks `sho` is held high per transmitted byte (≥1).
- `SHO_LOW`, default 25: chip clocks `sho` is held low after each byte (≥1).
- `RX_TIMEOUT`, default 4096: idle chip clocks mid-frame before the receive frame is discarded.
- `clk` in 1: chip clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `shi` in 1: byte strobe from the platform; asynchronous to `clk`, level held ≥3 clocks high and ≥3 clocks low.
- `user_data` in 8: byte from the platform; stable from ≥4 clocks before the `shi` rise until `shi` falls.
- `id` in 1: 1 = encrypt, 0 = decrypt; sampled at `core_start`.
- `chip_data` out 8: transmitted byte.
- `sho` out 1: byte strobe to the platform.
- `core_start` out 1: one-cycle pulse; the core captures key, text and mode.
- `core_enc` out 1: registered `id`.
- `core_key` out 128: assembled key.
- `core_text` out 128: assembled text.
- `core_done` in 1: one-cycle pulse; `core_result` is valid in that cycle.
- `core_result` in 128: core output block.
- `busy` out 1: high in every state except RX.
- `overrun` out 1: sticky; a byte arrived while `busy`. Cleared only by `rst`.

## Operation
- `shi` passes through a 2-flop synchronizer, then a rising-edge detector. The resulting `byte_ev` is a one-cycle pulse.
- States: RX, WAIT, TX_HI, TX_LO.
- **RX** (reset state)
  - On `byte_ev`, capture `user_data` into the shift register at position `cnt`. Bytes 0–15 form the key, with byte 0 = `core_key[127:120]`. Bytes 16–31 form the text, with byte 16 = `core_text[127:120]`. Then increment the 5-bit `cnt`.
  - When `cnt`≠0 and no `byte_ev` occurs for `RX_TIMEOUT` consecutive clocks, clear `cnt` to 0. The partial frame is discarded and the key/text registers are not cleared.
  - On `byte_ev` with `cnt`=31: store the byte, set `cnt`=0, assert `core_start` in the next cycle, latch `core_enc`=`id`, and go to WAIT.
- **WAIT**
  - On `core_done`, load `core_result` into the 128-bit TX shift register, set byte index 0, and go to TX_HI.
- **TX_HI**
  - `chip_data` = `tx_sr[127:120]`, `sho`=1, held for `SHO_HIGH` clocks, then go to TX_LO.
- **TX_LO**
  - `sho`=0 and `chip_data` held for `SHO_LOW` clocks.
  - Then shift `tx_sr` left by 8 and increment the index.
  - After index 15, go to RX with `chip_data`=0; otherwise go to TX_HI.
- A `byte_ev` in WAIT, TX_HI or TX_LO is dropped and sets `overrun`.
- `core_done` outside WAIT is ignored.

## Timing
- Reset values: `sho`=0, `chip_data`=0, `core_start`=0, `core_enc`=0, `core_key`=0, `core_text`=0, `busy`=0, `overrun`=0, state RX, `cnt`=0.
- `shi` rise to `byte_ev`: 2–3 clocks. `user_data` is sampled in the `byte_ev` cycle.
- Last-byte `byte_ev` to `core_start`: 1 clock. `busy` rises in the same cycle as `core_start`.
- `core_done` to first `sho` rise: 1 clock.
- Byte period: `SHO_HIGH`+`SHO_LOW` clocks. A full response takes 16×(`SHO_HIGH`+`SHO_LOW`) clocks.
- After the last TX_LO, state is RX and `busy`=0 in the next cycle.
- A `byte_ev` in that first RX cycle is accepted as byte 0.
- `rst` asserted in any state returns all outputs to their reset values in the next cycle. It also clears the synchronizer flops, so a `shi` held high through reset does not produce a `byte_ev`.
- `core_done` and `byte_ev` in the same WAIT cycle: the result is loaded and `overrun` is set.

## Structure
- Shared package `aes_io_pkg` holds:
  - the state encoding (RX=2'd0, WAIT=2'd1, TX_HI=2'd2, TX_LO=2'd3);
  - `FRAME_BYTES`=32 and `BLOCK_BYTES`=16.
- One sub-module, `sync_rise`: 2-flop synchronizer plus rising-edge detect, with synchronous active-high reset. It is instantiated once, for `shi`.
- Counters: 5-bit `cnt`, 4-bit TX index, phase counter sized for max(`SHO_HIGH`,`SHO_LOW`), and timeout counter sized for `RX_TIMEOUT`.

## Test plan
- **Single encrypt frame.** Send key bytes 00..0f, then text 00,11,22,…,ff, with `id`=1.
  - `core_key`=000102…0f and `core_text`=00112233445566778899aabbccddeeff at `core_start`, and `core_enc`=1.
  - Model core returns 69c4e0d86a7b0430d8cdb78070b4c55a; platform receives bytes 69,c4,…,5a.
  - Each byte has `sho` high for exactly 25 clocks.
- **Decrypt frame.** Same key, text 69c4…5a, `id`=0.
  - `core_enc`=0 and `core_text` matches the sent text.
  - Returned bytes equal the model result.
- **Timeout resync.** Send 5 bytes, idle for 4096 clocks, then send a full 32-byte frame.
  - Exactly one `core_start`, with key/text from the second burst only.
- **Overrun.** Send one extra `shi` pulse during WAIT and one during TX_HI.
  - `overrun`=1 and stays 1; response bytes are unchanged; the next frame starts at byte 0.
- **Reset mid-transmit.** Assert `rst` during byte 7 TX_HI.
  - Next cycle `sho`=0, `chip_data`=0, `busy`=0.
  - A following full frame completes normally.
- **Back-to-back.** Send a new frame's byte 0 `shi` edge in the first cycle after the previous response ends.
  - It is accepted; no `overrun`.

Source files
------------

// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES chip byte-stream port: FSM encoding and frame geometry.
package aes_io_pkg;

  typedef enum logic [1:0] {
    ST_RX    = 2'd0,
    ST_WAIT  = 2'd1,
    ST_TX_HI = 2'd2,
    ST_TX_LO = 2'd3
  } port_state_e;

  localparam int FRAME_BYTES = 32;
  localparam int BLOCK_BYTES = 16;

endpackage

// File: rtl/aes_byte_port_sync_rise.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [2:0] vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make each flop take its neighbour's pre-edge value,
      // which is what turns these three lines into a pipeline instead of a single wire.
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      vld_q  <= {vld_q[1:0], 1'b1};
    end
  end

  // prev_q must hold a genuinely sampled level, so a strobe held high through reset is no edge.
  assign rise_o = sync_q & ~prev_q & vld_q[2];

endmodule

// File: rtl/aes_byte_port.sv
// Responder end of the 9-bit platform link: assembles key/text frames for the AES core
// and streams the 128-bit result back one strobed byte at a time.
module aes_byte_port
  import aes_io_pkg::*;
#(
  parameter int SHO_HIGH   = 25,
  parameter int SHO_LOW    = 25,
  parameter int RX_TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shi,
  input  logic [7:0]   user_data,
  input  logic         id,
  output logic [7:0]   chip_data,
  output logic         sho,
  output logic         core_start,
  output logic         core_enc,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         busy,
  output logic         overrun
);

  localparam int PH_MAX = (SHO_HIGH > SHO_LOW) ? SHO_HIGH : SHO_LOW;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(RX_TIMEOUT + 1);

  localparam logic [PH_W-1:0] PH_HI_LAST = PH_W'(SHO_HIGH - 1);
  localparam logic [PH_W-1:0] PH_LO_LAST = PH_W'(SHO_LOW - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(RX_TIMEOUT - 1);
  localparam logic [4:0]      CNT_LAST   = 5'(FRAME_BYTES - 1);
  localparam logic [3:0]      IDX_LAST   = 4'(BLOCK_BYTES - 1);

  port_state_e     state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [3:0]      idx_q, idx_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    text_q, text_d;
  logic [127:0]    tx_sr_q, tx_sr_d;
  logic            start_q, start_d;
  logic            enc_q, enc_d;
  logic            ovr_q, ovr_d;
  logic            byte_ev;

  sync_rise u_shi_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (shi),
    .rise_o  (byte_ev)
  );

  always_comb begin
    // NOTE: every next-state signal is defaulted before any branch; a path that left one
    // unassigned would make it hold its value combinationally, i.e. infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    key_d   = key_q;
    text_d  = text_q;
    tx_sr_d = tx_sr_q;
    start_d = 1'b0;
    enc_d   = enc_q;
    ovr_d   = ovr_q | (byte_ev & (state_q != ST_RX));

    case (state_q)
      ST_RX: begin
        if (byte_ev) begin
          // Byte 0 lands in the top byte of the key, byte 16 in the top byte of the text.
          for (int b = 0; b < BLOCK_BYTES; b++) begin
            if (cnt_q == 5'(b))
              key_d[8*(BLOCK_BYTES-1-b) +: 8] = user_data;
            if (cnt_q == 5'(b + BLOCK_BYTES))
              text_d[8*(BLOCK_BYTES-1-b) +: 8] = user_data;
          end
          cnt_d = cnt_q + 5'd1;
          to_d  = '0;
          if (cnt_q == CNT_LAST) begin
            start_d = 1'b1;
            enc_d   = id;
            state_d = ST_WAIT;
          end
        end else if (cnt_q != 5'd0) begin
          if (to_q == TO_LAST) begin
            cnt_d = '0;
            to_d  = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end

      ST_WAIT: begin
        if (core_done) begin
          tx_sr_d = core_result;
          idx_d   = '0;
          ph_d    = '0;
          state_d = ST_TX_HI;
        end
      end

      ST_TX_HI: begin
        if (ph_q == PH_HI_LAST) begin
          ph_d    = '0;
          state_d = ST_TX_LO;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      ST_TX_LO: begin
        if (ph_q == PH_LO_LAST) begin
          ph_d    = '0;
          tx_sr_d = {tx_sr_q[119:0], 8'h00};
          idx_d   = idx_q + 4'd1;
          state_d = (idx_q == IDX_LAST) ? ST_RX : ST_TX_HI;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide key/text/tx registers are ordinary flops, not a memory array, and the
      // core-facing buses must read zero after reset, so they belong in the reset branch.
      state_q <= ST_RX;
      cnt_q   <= '0;
      to_q    <= '0;
      ph_q    <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      text_q  <= '0;
      tx_sr_q <= '0;
      start_q <= 1'b0;
      enc_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      text_q  <= text_d;
      tx_sr_q <= tx_sr_d;
      start_q <= start_d;
      enc_q   <= enc_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sho        = (state_q == ST_TX_HI);
  assign chip_data  = (state_q == ST_TX_HI || state_q == ST_TX_LO) ? tx_sr_q[127:120] : 8'h00;
  assign busy       = (state_q != ST_RX);
  assign core_start = start_q;
  assign core_enc   = enc_q;
  assign core_key   = key_q;
  assign core_text  = text_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_aes_byte_port.sv
// Directed-plus-random bench for aes_byte_port acting as both the platform and the AES core.
module tb_aes_byte_port;

  localparam int SHO_H     = 25;
  localparam int SHO_L     = 25;
  localparam int RESP_CLKS = 16 * (SHO_H + SHO_L);

  logic         clk = 1'b0;
  logic         rst, shi, id, core_done;
  logic [7:0]   user_data, chip_data;
  logic         sho, core_start, core_enc, busy, overrun;
  logic [127:0] core_key, core_text, core_result;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state, sampled on the falling edge.
  int           cyc = 0;
  int           start_cnt = 0;
  int           first_rise = 0;
  int           busy_fall = 0;
  int           hi_run = 0;
  logic         prev_sho = 1'b0;
  logic         prev_busy = 1'b0;
  logic [127:0] cap_key, cap_text;
  logic         cap_enc, cap_busy;
  logic [7:0]   rx_q[$];
  int           hi_q[$];

  aes_byte_port #(
    .SHO_HIGH   (SHO_H),
    .SHO_LOW    (SHO_L),
    .RX_TIMEOUT (4096)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .shi         (shi),
    .user_data   (user_data),
    .id          (id),
    .chip_data   (chip_data),
    .sho         (sho),
    .core_start  (core_start),
    .core_enc    (core_enc),
    .core_key    (core_key),
    .core_text   (core_text),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (core_start) begin
      start_cnt++;
      cap_key  = core_key;
      cap_text = core_text;
      cap_enc  = core_enc;
      cap_busy = busy;
    end
    if (sho) begin
      if (!prev_sho) begin
        if (rx_q.size() == 0) first_rise = cyc;
        rx_q.push_back(chip_data);
      end
      hi_run++;
    end else if (prev_sho) begin
      hi_q.push_back(hi_run);
      hi_run = 0;
    end
    if (prev_busy && !busy) busy_fall = cyc;
    prev_sho  = sho;
    prev_busy = busy;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Frame byte i: bytes 0..15 are the key, 16..31 the text, most significant byte first.
  function automatic logic [7:0] frame_byte(input logic [127:0] k, input logic [127:0] t,
                                            input int i);
    if (i < 16) return 8'(k >> (8 * (15 - i)));
    return 8'(t >> (8 * (31 - i)));
  endfunction

  task automatic send_byte(input logic [7:0] b);
    user_data = b;
    repeat (4) @(negedge clk);
    shi = 1'b1;
    repeat (4) @(negedge clk);
    shi = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [127:0] k, input logic [127:0] t, input int lo,
                            input int hi);
    for (int i = lo; i <= hi; i++) send_byte(frame_byte(k, t, i));
  endtask

  task automatic check_start(input string tag, input logic [127:0] k, input logic [127:0] t,
                             input logic e, input int s0);
    for (int w = 0; w < 20 && start_cnt == s0; w++) @(negedge clk);
    chk({tag, ".starts"}, 128'(start_cnt - s0), 128'd1);
    chk({tag, ".key"}, cap_key, k);
    chk({tag, ".text"}, cap_text, t);
    chk({tag, ".enc"}, 128'(cap_enc), 128'(e));
    chk({tag, ".busy_at_start"}, 128'(cap_busy), 128'd1);
  endtask

  // Acts as the core: one-cycle done pulse, then garbage on the result bus.
  task automatic respond(input string tag, input logic [127:0] res);
    rx_q.delete();
    hi_q.delete();
    chk({tag, ".sho_before_done"}, 128'(sho), 128'd0);
    core_result = res;
    core_done   = 1'b1;
    @(negedge clk);
    core_done   = 1'b0;
    core_result = rnd128();
    chk({tag, ".sho_latency"}, 128'(sho), 128'd1);
  endtask

  task automatic collect(input string tag, input logic [127:0] res);
    logic [7:0] ob;
    int         hl;
    for (int w = 0; w < RESP_CLKS + 200 && !(rx_q.size() == 16 && !busy); w++)
      @(negedge clk);
    @(negedge clk);
    chk({tag, ".resp_done"}, 128'(rx_q.size() == 16 && !busy), 128'd1);
    for (int i = 0; i < 16; i++) begin
      ob = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      hl = (i < hi_q.size()) ? hi_q[i] : -1;
      chk($sformatf("%s.byte%0d", tag, i), 128'(ob), 128'(8'(res >> (8 * (15 - i)))));
      chk($sformatf("%s.sho_high%0d", tag, i), 128'(hl), 128'(SHO_H));
    end
    chk({tag, ".resp_clocks"}, 128'(busy_fall - first_rise), 128'(RESP_CLKS));
    chk({tag, ".chip_data_idle"}, 128'(chip_data), 128'd0);
  endtask

  initial begin
    logic [127:0] k, t, r, k2, t2;
    logic         e;
    int           s0;

    rst = 1'b1; shi = 1'b0; id = 1'b0; user_data = 8'h00;
    core_done = 1'b0; core_result = '0;
    repeat (3) @(negedge clk);
    chk("rst.sho", 128'(sho), 128'd0);
    chk("rst.chip_data", 128'(chip_data), 128'd0);
    chk("rst.core_start", 128'(core_start), 128'd0);
    chk("rst.core_enc", 128'(core_enc), 128'd0);
    chk("rst.core_key", core_key, 128'd0);
    chk("rst.core_text", core_text, 128'd0);
    chk("rst.busy", 128'(busy), 128'd0);
    chk("rst.overrun", 128'(overrun), 128'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Known-answer encrypt frame.
    k = 128'h000102030405060708090a0b0c0d0e0f;
    t = 128'h00112233445566778899aabbccddeeff;
    r = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    id = 1'b1; s0 = start_cnt;
    send_bytes(k, t, 0, 31);
    check_start("enc", k, t, 1'b1, s0);
    respond("enc", r);
    collect("enc", r);

    // Decrypt frame: send the ciphertext back, core returns the plaintext.
    id = 1'b0; s0 = start_cnt;
    send_bytes(k, r, 0, 31);
    check_start("dec", k, r, 1'b0, s0);
    respond("dec", t);
    collect("dec", t);

    // Idle gap just short of the timeout: the frame continues where it left off.
    k = rnd128(); t = rnd128(); r = rnd128(); e = 1'($urandom()); id = e; s0 = start_cnt;
    send_bytes(k, t, 0, 4);
    repeat (4000) @(negedge clk);
    chk("gap.no_start", 128'(start_cnt - s0), 128'd0);
    send_bytes(k, t, 5, 31);
    check_start("gap", k, t, e, s0);
    respond("gap", r);
    collect("gap", r);

    // Idle gap past the timeout: the partial burst is discarded.
    k2 = rnd128(); t2 = rnd128();
    k = rnd128(); t = rnd128(); r = rnd128(); e = 1'($urandom()); id = e; s0 = start_cnt;
    send_bytes(k2, t2, 0, 4);
    repeat (4100) @(negedge clk);
    send_bytes(k, t, 0, 31);
    check_start("tmo", k, t, e, s0);
    respond("tmo", r);
    collect("tmo", r);

    // Overrun: stray strobes during WAIT and during TX_HI.
    k = rnd128(); t = rnd128(); r = rnd128(); e = 1'($urandom()); id = e; s0 = start_cnt;
    chk("ovr.clear_before", 128'(overrun), 128'd0);
    send_bytes(k, t, 0, 31);
    check_start("ovr", k, t, e, s0);
    send_byte(8'($urandom()));
    chk("ovr.in_wait", 128'(overrun), 128'd1);
    respond("ovr", r);
    repeat (2) @(negedge clk);
    send_byte(8'($urandom()));
    chk("ovr.in_tx_hi", 128'(overrun), 128'd1);
    collect("ovr", r);
    k = rnd128(); t = rnd128(); r = rnd128(); e = 1'($urandom()); id = e; s0 = start_cnt;
    send_bytes(k, t, 0, 31);
    check_start("ovr_next", k, t, e, s0);
    respond("ovr_next", r);
    collect("ovr_next", r);
    chk("ovr.sticky", 128'(overrun), 128'd1);

    // Reset during byte 7 high phase, with shi rising and held through reset.
    k = rnd128(); t = rnd128(); r = rnd128(); e = 1'($urandom()); id = e; s0 = start_cnt;
    send_bytes(k, t, 0, 31);
    check_start("rstx", k, t, e, s0);
    respond("rstx", r);
    for (int w = 0; w < RESP_CLKS && rx_q.size() < 8; w++) @(negedge clk);
    chk("rstx.reached_byte7", 128'(rx_q.size()), 128'd8);
    repeat (3) @(negedge clk);
    user_data = 8'ha5; shi = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rstx.sho", 128'(sho), 128'd0);
    chk("rstx.chip_data", 128'(chip_data), 128'd0);
    chk("rstx.busy", 128'(busy), 128'd0);
    chk("rstx.overrun", 128'(overrun), 128'd0);
    chk("rstx.core_key", core_key, 128'd0);
    chk("rstx.core_enc", 128'(core_enc), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstx.shi_held_no_byte", core_key, 128'd0);
    core_result = rnd128(); core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("rstx.done_ignored", 128'(busy), 128'd0);
    shi = 1'b0;
    repeat (4) @(negedge clk);
    k = rnd128(); t = rnd128(); r = rnd128(); e = 1'($urandom()); id = e; s0 = start_cnt;
    send_bytes(k, t, 0, 31);
    check_start("rstx_next", k, t, e, s0);
    respond("rstx_next", r);
    collect("rstx_next", r);

    // Back-to-back: next frame's first strobe lands in the first RX cycle after the response.
    k = rnd128(); t = rnd128(); r = rnd128(); e = 1'($urandom()); id = e; s0 = start_cnt;
    k2 = rnd128(); t2 = rnd128();
    send_bytes(k, t, 0, 31);
    check_start("b2b", k, t, e, s0);
    user_data = frame_byte(k2, t2, 0);
    respond("b2b", r);
    repeat (RESP_CLKS - 2) @(negedge clk);
    shi = 1'b1;
    repeat (4) @(negedge clk);
    shi = 1'b0;
    repeat (4) @(negedge clk);
    collect("b2b", r);
    r = rnd128(); e = 1'($urandom()); id = e; s0 = start_cnt;
    send_bytes(k2, t2, 1, 31);
    check_start("b2b_next", k2, t2, e, s0);
    chk("b2b.no_overrun", 128'(overrun), 128'd0);
    respond("b2b_next", r);
    collect("b2b_next", r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
